// File: rtl/tick_scheduler_pkg.sv
// tick_scheduler_pkg
// Shared definitions for the tick scheduler: task-id constants, the
// dispatcher state type, default divisors and small task-id helpers.
package tick_scheduler_pkg;

    typedef logic [1:0] task_id_t;

    localparam int NUM_TASKS = 3;

    localparam task_id_t TASK_SND = 2'd0;
    localparam task_id_t TASK_PHY = 2'd1;
    localparam task_id_t TASK_ANI = 2'd2;

    // Divisors for a 12 MHz clock.
    localparam int DEF_PIX_DIV = 6;        // 2 MHz pixel strobe
    localparam int DEF_SND_DIV = 12000;    // 1000 Hz sound task
    localparam int DEF_PHY_DIV = 300000;   // 40 Hz physics task
    localparam int DEF_ANI_DIV = 1200000;  // 10 Hz animation task

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } disp_state_t;

    // Fixed priority: sound beats physics beats animation.
    function automatic task_id_t lowest_task(input logic [NUM_TASKS-1:0] pending);
        if (pending[0])
            return TASK_SND;
        else if (pending[1])
            return TASK_PHY;
        else
            return TASK_ANI;
    endfunction

    function automatic logic [NUM_TASKS-1:0] task_onehot(input task_id_t id);
        logic [NUM_TASKS-1:0] mask;
        case (id)
            TASK_SND: mask = 3'b001;
            TASK_PHY: mask = 3'b010;
            TASK_ANI: mask = 3'b100;
            default:  mask = 3'b000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/tick_scheduler_tick_gen.sv
// tick_gen
// Free-running modulo-DIV counter producing a one-cycle tick on the
// cycle the counter sits at DIV-1. While en is low the counter holds and
// the tick is suppressed, so counting resumes from where it stopped.
//   clk12Mhz : clock
//   rst      : asynchronous active-high reset
//   en       : count enable
//   tick     : high for one cycle every DIV enabled cycles
module tick_gen #(
    parameter int DIV = 6
) (
    input  logic clk12Mhz,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int              CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk12Mhz or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (en)
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
    end

    assign tick = en && (r_cnt == LAST);

endmodule

// File: rtl/tick_scheduler.sv
// tick_scheduler
// Generates a free-running pixel clock-enable and three periodic task
// ticks (sound, physics, animation). Task ticks set pending bits that a
// small dispatcher presents one at a time to a shared update engine with
// a req/ack handshake. Lost ticks are recorded in sticky overrun flags.
//   clk12Mhz : sole clock
//   rst      : asynchronous active-high reset
//   pause    : freezes physics and animation tick generation
//   task_ack : update engine accepts the presented task
//   ovr_clr  : one-cycle pulse clearing the overrun flags
//   pix_en   : one-cycle strobe every PIX_DIV cycles
//   task_req : a task is being presented
//   task_id  : presented task (0 sound, 1 physics, 2 animation)
//   overrun  : sticky per-task lost-tick flags
module tick_scheduler
    import tick_scheduler_pkg::*;
#(
    parameter int PIX_DIV = DEF_PIX_DIV,
    parameter int SND_DIV = DEF_SND_DIV,
    parameter int PHY_DIV = DEF_PHY_DIV,
    parameter int ANI_DIV = DEF_ANI_DIV
) (
    input  logic                 clk12Mhz,
    input  logic                 rst,
    input  logic                 pause,
    input  logic                 task_ack,
    input  logic                 ovr_clr,
    output logic                 pix_en,
    output logic                 task_req,
    output logic [1:0]           task_id,
    output logic [NUM_TASKS-1:0] overrun
);

    localparam int TASK_DIV [NUM_TASKS] = '{SND_DIV, PHY_DIV, ANI_DIV};

    logic                 w_pix_tick;
    logic [NUM_TASKS-1:0] w_task_en;
    logic [NUM_TASKS-1:0] w_task_tick;

    logic                 r_pix_en;
    logic [NUM_TASKS-1:0] r_pending;
    logic [NUM_TASKS-1:0] r_overrun;
    logic                 r_task_req;
    task_id_t             r_task_id;
    disp_state_t          r_state;

    disp_state_t          w_state_next;
    logic                 w_task_req_next;
    task_id_t             w_task_id_next;
    logic [NUM_TASKS-1:0] w_ack_clr;
    logic [NUM_TASKS-1:0] w_ovr_evt;
    logic [NUM_TASKS-1:0] w_pending_next;
    logic [NUM_TASKS-1:0] w_overrun_next;

    // ---------------- tick generation ----------------
    tick_gen #(.DIV(PIX_DIV)) u_pix_tick (
        .clk12Mhz (clk12Mhz),
        .rst      (rst),
        .en       (1'b1),
        .tick     (w_pix_tick)
    );

    // Sound keeps running through pause; physics and animation freeze.
    assign w_task_en = {~pause, ~pause, 1'b1};

    generate
        for (genvar gi = 0; gi < NUM_TASKS; gi++) begin : g_task_tick
            tick_gen #(.DIV(TASK_DIV[gi])) u_tick (
                .clk12Mhz (clk12Mhz),
                .rst      (rst),
                .en       (w_task_en[gi]),
                .tick     (w_task_tick[gi])
            );
        end
    endgenerate

    // ---------------- dispatcher FSM ----------------
    always_ff @(posedge clk12Mhz or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (|r_pending) w_state_next = ST_REQ;
            ST_REQ:  if (task_ack)   w_state_next = ST_GAP;
            ST_GAP:                  w_state_next = ST_IDLE;
            default:                 w_state_next = ST_IDLE;
        endcase
    end

    // Outputs are computed one cycle ahead and registered, so task_req
    // rises the cycle after the IDLE decision and falls after the ack.
    always_comb begin
        w_task_req_next = 1'b0;
        w_task_id_next  = r_task_id;
        w_ack_clr       = '0;
        case (r_state)
            ST_IDLE: begin
                if (|r_pending) begin
                    w_task_req_next = 1'b1;
                    w_task_id_next  = lowest_task(r_pending);
                end
            end
            ST_REQ: begin
                if (task_ack)
                    w_ack_clr = task_onehot(r_task_id);
                else
                    w_task_req_next = 1'b1;
            end
            default: ;
        endcase
    end

    // ---------------- pending / overrun bookkeeping ----------------
    // A tick landing on a bit that is being acked this cycle re-arms it
    // cleanly; only a tick on a still-pending bit counts as lost.
    assign w_ovr_evt      = w_task_tick & r_pending & ~w_ack_clr;
    assign w_pending_next = w_task_tick | (r_pending & ~w_ack_clr);
    // A fresh overrun beats a simultaneous clear.
    assign w_overrun_next = (ovr_clr ? '0 : r_overrun) | w_ovr_evt;

    always_ff @(posedge clk12Mhz or posedge rst) begin
        if (rst) begin
            r_pix_en   <= 1'b0;
            r_pending  <= '0;
            r_overrun  <= '0;
            r_task_req <= 1'b0;
            r_task_id  <= TASK_SND;
        end else begin
            r_pix_en   <= w_pix_tick;
            r_pending  <= w_pending_next;
            r_overrun  <= w_overrun_next;
            r_task_req <= w_task_req_next;
            r_task_id  <= w_task_id_next;
        end
    end

    assign pix_en   = r_pix_en;
    assign task_req = r_task_req;
    assign task_id  = r_task_id;
    assign overrun  = r_overrun;

endmodule
